// File: rtl/tiny_fpga_cfg_ctrl.sv
// FPGA configuration controller: serializes a host byte stream LSB-first into a
// 1-bit fabric bitstream, checks the stream length and sequences cfg/run modes.
module tiny_fpga_cfg_ctrl #(
    parameter int CFG_BYTES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_cfg,
    input  logic       start_run,
    input  logic       stop,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic [7:0] s_tdata,
    input  logic       s_tlast,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tdata,
    output logic       m_tlast,
    output logic       cfg,
    output logic       run,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, CFG, READY, RUN, ERR} state_t;

    localparam logic [7:0] LAST_IDX = 8'(CFG_BYTES);

    state_t      state, next_state;
    logic [7:0]  shift_reg;
    logic [3:0]  bits_left;
    logic [7:0]  byte_cnt;
    logic        last_byte;
    logic        is_final;
    logic        len_err;
    logic        s_fire;
    logic        m_fire;

    always_comb begin
        is_final = (byte_cnt + 8'd1) == LAST_IDX;
        len_err  = s_tlast != is_final;
        // Refill during the last bit of a byte keeps the output gap-free; no
        // bytes are taken once the full bitstream length has been received.
        s_tready = (state == CFG) && (byte_cnt != LAST_IDX) &&
                   ((bits_left == 4'd0) || ((bits_left == 4'd1) && m_tready));
        m_tvalid = (state == CFG) && (bits_left != 4'd0);
        m_tdata  = shift_reg[0];
        m_tlast  = m_tvalid && last_byte && (bits_left == 4'd1);
        s_fire   = s_tvalid && s_tready;
        m_fire   = m_tvalid && m_tready;
        cfg      = (state == CFG);
        run      = (state == RUN);
        done     = (state == READY) || (state == RUN);
        err      = (state == ERR);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_cfg) next_state = CFG;
            CFG: begin
                if (s_fire && len_err)      next_state = ERR;
                else if (m_fire && m_tlast) next_state = READY;
            end
            READY: begin
                if (start_cfg)      next_state = CFG;
                else if (start_run) next_state = RUN;
            end
            RUN:     if (stop) next_state = READY;
            ERR:     if (start_cfg) next_state = CFG;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Outside CFG the datapath is held empty, so every CFG entry starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bits_left <= '0;
            byte_cnt  <= '0;
            last_byte <= 1'b0;
        end else if (state != CFG) begin
            shift_reg <= '0;
            bits_left <= '0;
            byte_cnt  <= '0;
            last_byte <= 1'b0;
        end else if (s_fire && !len_err) begin
            shift_reg <= s_tdata;
            bits_left <= 4'd8;
            byte_cnt  <= byte_cnt + 8'd1;
            last_byte <= is_final;
        end else if (m_fire) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bits_left <= bits_left - 4'd1;
        end
    end

endmodule

// File: tb/tb_tiny_fpga_cfg_ctrl.sv
// Directed bench for tiny_fpga_cfg_ctrl with CFG_BYTES=2: streaming, backpressure,
// length errors, mode sequencing and mid-configuration reset.
module tb_tiny_fpga_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_cfg = 1'b0;
    logic       start_run = 1'b0;
    logic       stop = 1'b0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tlast = 1'b0;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       m_tdata;
    logic       m_tlast;
    logic       cfg, run, done, err;

    int total = 0;
    int fails = 0;

    tiny_fpga_cfg_ctrl #(.CFG_BYTES(2)) dut (
        .clk(clk), .rst(rst), .start_cfg(start_cfg), .start_run(start_run), .stop(stop),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .cfg(cfg), .run(run), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {cfg, run, done, err, s_tready, m_tvalid}
    function automatic logic [7:0] status();
        return 8'({cfg, run, done, err, s_tready, m_tvalid});
    endfunction

    // Streams 0xA5, 0x3C (tlast on the second) and checks every output bit.
    // Entered and left at posedge+1.
    task automatic cfg_pattern(input bit bp, input string tag);
        logic [15:0] pat;
        int nc;
        int bi;
        pat = 16'h3CA5;
        nc  = bp ? 32 : 16;
        start_cfg = 1'b1;
        @(posedge clk); #1 start_cfg = 1'b0;
        s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b0; m_tready = 1'b1;
        @(negedge clk);
        chk({tag, " entry"}, status(), 8'b100010);
        @(posedge clk); #1 s_tdata = 8'h3C; s_tlast = 1'b1;
        for (int c = 0; c < nc; c++) begin
            m_tready = bp ? c[0] : 1'b1;
            bi = bp ? c / 2 : c;
            @(negedge clk);
            chk($sformatf("%s bit%0d", tag, c), 8'({m_tvalid, m_tdata, m_tlast}),
                8'({1'b1, pat[bi], 1'(bi == 15)}));
            @(posedge clk); #1;
            if (c == (bp ? 15 : 7)) s_tvalid = 1'b0;
        end
        m_tready = 1'b1;
        @(negedge clk);
        chk({tag, " done"}, status(), 8'b001000);
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        chk("reset state", status(), 8'b000000);
        chk("reset m_tlast", 8'(m_tlast), 8'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        stop = 1'b1; start_run = 1'b1;
        @(posedge clk); #1 stop = 1'b0; start_run = 1'b0;
        @(negedge clk);
        chk("idle ignores run/stop", status(), 8'b000000);
        @(posedge clk); #1;

        cfg_pattern(1'b0, "stream");

        // Mode sequencing
        start_run = 1'b1;
        @(posedge clk); #1 start_run = 1'b0;
        @(negedge clk);
        chk("enter run", status(), 8'b011000);
        @(posedge clk); #1 start_cfg = 1'b1;
        @(posedge clk); #1 start_cfg = 1'b0;
        @(negedge clk);
        chk("run ignores start_cfg", status(), 8'b011000);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        chk("stop to ready", status(), 8'b001000);
        @(posedge clk); #1 start_cfg = 1'b1; start_run = 1'b1;
        @(posedge clk); #1 start_cfg = 1'b0; start_run = 1'b0;
        @(negedge clk);
        chk("start_cfg wins", status(), 8'b100010);

        // Early s_tlast on byte 1
        @(posedge clk); #1 s_tvalid = 1'b1; s_tdata = 8'h01; s_tlast = 1'b1;
        @(negedge clk);
        chk("early tlast accepted", status(), 8'b100010);
        @(posedge clk); #1 s_tvalid = 1'b0; s_tlast = 1'b0;
        @(negedge clk);
        chk("early tlast err", status(), 8'b000100);
        @(posedge clk); #1 start_run = 1'b1;
        @(posedge clk); #1 start_run = 1'b0;
        @(negedge clk);
        chk("err ignores start_run", status(), 8'b000100);
        @(posedge clk); #1 start_cfg = 1'b1;
        @(posedge clk); #1 start_cfg = 1'b0;
        @(negedge clk);
        chk("err recover", status(), 8'b100010);

        // Missing s_tlast on final byte: 0x5A serialized, 0x77 rejected
        @(posedge clk); #1 s_tvalid = 1'b1; s_tdata = 8'h5A; s_tlast = 1'b0;
        @(posedge clk); #1 s_tdata = 8'h77;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'h5A;
            @(negedge clk);
            chk($sformatf("notlast bit%0d", i), 8'({m_tvalid, m_tdata, m_tlast}),
                8'({1'b1, b[i], 1'b0}));
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("missing tlast err", status(), 8'b000100);
        chk("missing tlast m_tlast", 8'(m_tlast), 8'h0);
        @(posedge clk); #1;

        cfg_pattern(1'b1, "backpressure");

        // Reset after 5 bits of the first byte
        start_cfg = 1'b1;
        @(posedge clk); #1 start_cfg = 1'b0;
        s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b0;
        @(posedge clk); #1 s_tvalid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst mid-cfg", status(), 8'b000000);
        chk("rst mid-cfg m_tlast", 8'(m_tlast), 8'h0);
        @(negedge clk); rst = 1'b0;
        s_tvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("no output after rst", status(), 8'b000000);
        s_tvalid = 1'b0;
        @(posedge clk); #1;

        cfg_pattern(1'b0, "restart");

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
